// File: rtl/timer_0_sched.sv
// timer_0_sched: round-robin scheduler that shares one Avalon interval timer among NREQ one-shot delay requesters.
// Define TIMER_0_SCHED_ABORT_EN to add per-requester abort/abort_ack handshakes.
`timescale 1ns/1ps
module timer_0_sched #(
   parameter int NREQ = 4,
   parameter int IDXW = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req,
   input  logic [32*NREQ-1:0]   req_delay,
   output logic [NREQ-1:0]      done,
   output logic                 busy,
   output logic [IDXW-1:0]      grant_idx,
   output logic [2:0]           tmr_address,
   output logic                 tmr_chipselect,
   output logic                 tmr_write_n,
   output logic [15:0]          tmr_writedata,
   input  logic                 tmr_irq
`ifdef TIMER_0_SCHED_ABORT_EN
   ,
   input  logic [NREQ-1:0]      abort,
   output logic [NREQ-1:0]      abort_ack
`endif
);

   typedef enum logic [3:0] {
      IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, CLR, DONE
`ifdef TIMER_0_SCHED_ABORT_EN
      , STOP, ABORTED
`endif
   } state_e;

   state_e            state_q, state_d;
   logic [IDXW-1:0]   ptr_q, ptr_d;
   logic [IDXW-1:0]   grant_q, grant_d;
   logic [15:0]       d_hi_q, d_hi_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic              busy_q, busy_d;
   logic [2:0]        addr_q, addr_d;
   logic              cs_q, cs_d;
   logic              wn_q, wn_d;
   logic [15:0]       wdata_q, wdata_d;
`ifdef TIMER_0_SCHED_ABORT_EN
   logic              aborted_q, aborted_d;
   logic [NREQ-1:0]   ack_q, ack_d;
`endif

   logic              found_hi, found_any;
   logic [IDXW-1:0]   win_hi, win_lo, win;
   logic [31:0]       dly_hi, dly_lo, win_delay;

   // Lowest set bit at or above the pointer wins; otherwise wrap to the lowest set bit overall.
   always_comb begin
      found_hi  = 1'b0;
      found_any = 1'b0;
      win_hi    = '0;
      win_lo    = '0;
      dly_hi    = '0;
      dly_lo    = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i] && (i >= int'(ptr_q))) begin
            found_hi = 1'b1;
            win_hi   = IDXW'(i);
            dly_hi   = req_delay[32*i +: 32];
         end
         if (req[i]) begin
            found_any = 1'b1;
            win_lo    = IDXW'(i);
            dly_lo    = req_delay[32*i +: 32];
         end
      end
      win       = found_hi ? win_hi : win_lo;
      win_delay = found_hi ? dly_hi : dly_lo;
   end

   // Bus outputs are registered, so each write is set up on the transition into its state.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      d_hi_d  = d_hi_q;
      done_d  = '0;
      addr_d  = addr_q;
      cs_d    = 1'b0;
      wn_d    = 1'b1;
      wdata_d = wdata_q;
`ifdef TIMER_0_SCHED_ABORT_EN
      aborted_d = aborted_q;
      ack_d     = '0;
`endif
      case (state_q)
         IDLE: begin
            if (found_any) begin
               grant_d = win;
               d_hi_d  = win_delay[31:16];
               if (win_delay == 32'd0) begin
                  state_d     = DONE;
                  done_d[win] = 1'b1;
               end else begin
                  state_d = WR_PL;
                  cs_d    = 1'b1;
                  wn_d    = 1'b0;
                  addr_d  = 3'd2;
                  wdata_d = win_delay[15:0];
               end
            end
         end
         WR_PL: begin
            state_d = WR_PH;
            cs_d    = 1'b1;
            wn_d    = 1'b0;
            addr_d  = 3'd3;
            wdata_d = d_hi_q;
         end
         WR_PH: begin
            state_d = WR_CTRL;
            cs_d    = 1'b1;
            wn_d    = 1'b0;
            addr_d  = 3'd1;
            wdata_d = 16'h0005;
         end
         WR_CTRL: state_d = WAIT_IRQ;
         WAIT_IRQ: begin
            if (tmr_irq) begin
               state_d = CLR;
               cs_d    = 1'b1;
               wn_d    = 1'b0;
               addr_d  = 3'd0;
               wdata_d = 16'h0000;
            end
         end
         CLR: begin
`ifdef TIMER_0_SCHED_ABORT_EN
            if (aborted_q) begin
               state_d        = ABORTED;
               ack_d[grant_q] = 1'b1;
            end else
`endif
            begin
               state_d         = DONE;
               done_d[grant_q] = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            ptr_d   = (grant_q == IDXW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
         end
`ifdef TIMER_0_SCHED_ABORT_EN
         STOP: begin
            state_d = CLR;
            cs_d    = 1'b1;
            wn_d    = 1'b0;
            addr_d  = 3'd0;
            wdata_d = 16'h0000;
         end
         ABORTED: begin
            state_d   = IDLE;
            aborted_d = 1'b0;
            ptr_d     = (grant_q == IDXW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
         end
`endif
         default: state_d = IDLE;
      endcase
`ifdef TIMER_0_SCHED_ABORT_EN
      // An abort overrides whatever the active state planned for the next cycle.
      if (abort[grant_q] && (state_q inside {WR_PL, WR_PH, WR_CTRL, WAIT_IRQ})) begin
         state_d   = STOP;
         aborted_d = 1'b1;
         cs_d      = 1'b1;
         wn_d      = 1'b0;
         addr_d    = 3'd1;
         wdata_d   = 16'h0008;
      end
`endif
      busy_d = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         d_hi_q  <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         addr_q  <= '0;
         cs_q    <= 1'b0;
         wn_q    <= 1'b1;
         wdata_q <= '0;
`ifdef TIMER_0_SCHED_ABORT_EN
         aborted_q <= 1'b0;
         ack_q     <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         d_hi_q  <= d_hi_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         addr_q  <= addr_d;
         cs_q    <= cs_d;
         wn_q    <= wn_d;
         wdata_q <= wdata_d;
`ifdef TIMER_0_SCHED_ABORT_EN
         aborted_q <= aborted_d;
         ack_q     <= ack_d;
`endif
      end
   end

   assign done           = done_q;
   assign busy           = busy_q;
   assign grant_idx      = grant_q;
   assign tmr_address    = addr_q;
   assign tmr_chipselect = cs_q;
   assign tmr_write_n    = wn_q;
   assign tmr_writedata  = wdata_q;
`ifdef TIMER_0_SCHED_ABORT_EN
   assign abort_ack      = ack_q;
`endif

endmodule

// File: tb/tb_timer_0_sched.sv
// Self-checking bench for timer_0_sched: behavioural timer plus a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_timer_0_sched;
   localparam int NREQ = 4;
   localparam int IDXW = 2;

   typedef struct packed {
      logic [2:0]  a;
      logic [15:0] d;
   } wr_t;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [NREQ-1:0]     req;
   logic [32*NREQ-1:0]  req_delay;
   logic [NREQ-1:0]     done;
   logic                busy;
   logic [IDXW-1:0]     grant_idx;
   logic [2:0]          tmr_address;
   logic                tmr_chipselect;
   logic                tmr_write_n;
   logic [15:0]         tmr_writedata;
   logic                tmr_irq;
`ifdef TIMER_0_SCHED_ABORT_EN
   logic [NREQ-1:0]     abort;
   logic [NREQ-1:0]     abort_ack;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int bad_bus = 0;
   int bad_done = 0;
   wr_t wq[$];
   wr_t ew[$];
   int  dq[$];
   int  aq[$];
   logic [NREQ-1:0] done_prev = '0;

   always #5 clk = ~clk;

   timer_0_sched #(.NREQ(NREQ), .IDXW(IDXW)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_delay(req_delay),
      .done(done), .busy(busy), .grant_idx(grant_idx),
      .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
      .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
      .tmr_irq(tmr_irq)
`ifdef TIMER_0_SCHED_ABORT_EN
      , .abort(abort), .abort_ack(abort_ack)
`endif
   );

   // Behavioural interval timer: one-shot countdown of 'period' cycles, TO cleared by a status write.
   logic [31:0] t_per, t_cnt;
   logic        t_run, t_to, t_ito;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         t_per <= '0; t_cnt <= '0; t_run <= 1'b0; t_to <= 1'b0; t_ito <= 1'b0;
      end else if (tmr_chipselect && !tmr_write_n) begin
         case (tmr_address)
            3'd0: t_to <= 1'b0;
            3'd1: begin
               t_ito <= tmr_writedata[0];
               if (tmr_writedata[3]) t_run <= 1'b0;
               else if (tmr_writedata[2]) begin
                  t_run <= 1'b1;
                  t_cnt <= t_per;
               end
            end
            3'd2: begin t_per[15:0]  <= tmr_writedata; t_run <= 1'b0; end
            3'd3: begin t_per[31:16] <= tmr_writedata; t_run <= 1'b0; end
            default: ;
         endcase
      end else if (t_run) begin
         if (t_cnt <= 32'd1) begin
            t_to  <= 1'b1;
            t_run <= 1'b0;
         end else begin
            t_cnt <= t_cnt - 32'd1;
         end
      end
   end
   assign tmr_irq = t_to & t_ito;

   // Bus/pulse monitor, sampled on the inactive edge.
   always @(negedge clk) begin
      if (tmr_chipselect !== !tmr_write_n) bad_bus++;
      if (tmr_chipselect === 1'b1) wq.push_back({tmr_address, tmr_writedata});
      if ($countones(done) > 1 || (done & done_prev) != '0) bad_done++;
      for (int i = 0; i < NREQ; i++) if (done[i]) dq.push_back(i);
      done_prev = done;
`ifdef TIMER_0_SCHED_ABORT_EN
      for (int i = 0; i < NREQ; i++) if (abort_ack[i]) aq.push_back(i);
`endif
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   function automatic int model_next(input logic [NREQ-1:0] m, input int p);
      for (int k = 0; k < NREQ; k++) if (m[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   task automatic expect_delay(input logic [31:0] d);
      ew.delete();
      if (d != 32'd0) begin
         ew.push_back({3'd2, d[15:0]});
         ew.push_back({3'd3, d[31:16]});
         ew.push_back({3'd1, 16'h0005});
         ew.push_back({3'd0, 16'h0000});
      end
   endtask

   task automatic compare_writes(input string tag);
      check({tag, "_count"}, wq.size(), ew.size());
      for (int i = 0; i < wq.size() && i < ew.size(); i++) check(tag, wq[i], ew[i]);
      wq.delete();
      ew.delete();
   endtask

   task automatic wait_done(output int idx, input int budget);
      int t;
      t = 0;
      while (dq.size() == 0 && t < budget) begin
         cyc(1);
         t++;
      end
      check("done_seen", dq.size() != 0, 1);
      idx = (dq.size() != 0) ? dq.pop_front() : -1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req     = '0;
      cyc(2);
      reset_n = 1'b1;
      cyc(1);
      wq.delete(); dq.delete(); aq.delete();
   endtask

   initial begin
      int ptr, g, idx, t;
      logic [NREQ-1:0] m;
      logic [31:0] dl [NREQ];

      reset_n   = 1'b0;
      req       = '0;
      req_delay = '0;
`ifdef TIMER_0_SCHED_ABORT_EN
      abort     = '0;
`endif
      ptr = 0;
      cyc(3);
      reset_n = 1'b1;
      cyc(1);

      // Idle defaults for 20 cycles.
      check("rst_grant_idx", grant_idx, 0);
      check("rst_address", tmr_address, 0);
      check("rst_writedata", tmr_writedata, 0);
      for (int i = 0; i < 20; i++) begin
         check("idle_cs", tmr_chipselect, 0);
         check("idle_wn", tmr_write_n, 1);
         check("idle_busy", busy, 0);
         check("idle_done", done, 0);
         cyc(1);
      end

      // Long delay with a nonzero high half on requester 1.
      req_delay[63:32] = 32'h0001_0003;
      req[1] = 1'b1;
      wait_done(idx, 70000);
      check("long_idx", idx, 1);
      check("long_grant_idx", grant_idx, 1);
      expect_delay(32'h0001_0003);
      compare_writes("long_wr");
      req[1] = 1'b0;
      cyc(2);
      check("long_busy_after", busy, 0);
      check("long_single_done", dq.size(), 0);

      // All four held, delay 5: round-robin from pointer 0 gives 0,1,2,3,0.
      do_reset();
      ptr = 0;
      for (int i = 0; i < NREQ; i++) req_delay[32*i +: 32] = 32'd5;
      req = '1;
      for (int n = 0; n < 5; n++) begin
         g = model_next('1, ptr);
         wait_done(idx, 200);
         check("rr_all_idx", idx, g);
         check("rr_all_order", idx, n % NREQ);
         expect_delay(32'd5);
         compare_writes("rr_all_wr");
         ptr = (g + 1) % NREQ;
      end
      req = '0;
      cyc(3);
      check("rr_all_busy", busy, 0);

      // Zero delay: done without any bus activity.
      req_delay[95:64] = 32'd0;
      req[2] = 1'b1;
      t = 0;
      while (dq.size() == 0 && t < 5) begin
         cyc(1);
         t++;
      end
      check("d0_latency_le2", (t >= 1 && t <= 2), 1);
      idx = (dq.size() != 0) ? dq.pop_front() : -1;
      check("d0_idx", idx, 2);
      req[2] = 1'b0;
      expect_delay(32'd0);
      compare_writes("d0_wr");
      ptr = 3;
      cyc(2);

      // Asynchronous reset during WAIT_IRQ, then a clean restart.
      req_delay[31:0] = 32'd1000;
      req[0] = 1'b1;
      t = 0;
      while (wq.size() < 3 && t < 10) begin
         cyc(1);
         t++;
      end
      check("rstw_writes_seen", wq.size(), 3);
      cyc(10);
      check("rstw_busy", busy, 1);
      reset_n = 1'b0;
      req = '0;
      #1;
      check("rstw_cs", tmr_chipselect, 0);
      check("rstw_wn", tmr_write_n, 1);
      check("rstw_addr", tmr_address, 0);
      check("rstw_wdata", tmr_writedata, 0);
      check("rstw_busy0", busy, 0);
      check("rstw_done", done, 0);
      check("rstw_grant", grant_idx, 0);
      cyc(2);
      reset_n = 1'b1;
      cyc(1);
      wq.delete(); dq.delete();
      ptr = 0;
      req_delay[31:0] = 32'd7;
      req[0] = 1'b1;
      wait_done(idx, 200);
      check("restart_idx", idx, 0);
      expect_delay(32'd7);
      compare_writes("restart_wr");
      req[0] = 1'b0;
      ptr = 1;
      cyc(1);

      // Randomized rounds against the round-robin model; granted delay is scrambled after grant.
      for (int r = 0; r < 8; r++) begin
         m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         for (int i = 0; i < NREQ; i++) begin
            dl[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 30));
            req_delay[32*i +: 32] = dl[i];
         end
         req = m;
         while (m != '0) begin
            g = model_next(m, ptr);
            t = 0;
            while (!busy && t < 10) begin
               cyc(1);
               t++;
            end
            req_delay[32*g +: 32] = $urandom;
            wait_done(idx, 200);
            check("rnd_grant", idx, g);
            check("rnd_grant_idx", grant_idx, g);
            expect_delay(dl[g]);
            compare_writes("rnd_wr");
            req = req & ~(NREQ'(1) << g);
            m   = m & ~(NREQ'(1) << g);
            ptr = (g + 1) % NREQ;
            cyc(1);
         end
      end

`ifdef TIMER_0_SCHED_ABORT_EN
      // Abort of the granted requester in WAIT_IRQ; a foreign abort is ignored.
      cyc(2);
      wq.delete(); dq.delete(); aq.delete();
      req_delay[127:96] = 32'd1000;
      req[3] = 1'b1;
      t = 0;
      while (wq.size() < 3 && t < 20) begin
         cyc(1);
         t++;
      end
      cyc(50);
      abort[1] = 1'b1;
      cyc(1);
      abort[1] = 1'b0;
      abort[3] = 1'b1;
      cyc(1);
      abort[3] = 1'b0;
      t = 0;
      while (aq.size() == 0 && t < 20) begin
         cyc(1);
         t++;
      end
      check("abort_ack_seen", aq.size() != 0, 1);
      idx = (aq.size() != 0) ? aq.pop_front() : -1;
      check("abort_ack_idx", idx, 3);
      req[3] = 1'b0;
      cyc(3);
      check("abort_no_done", dq.size(), 0);
      check("abort_busy", busy, 0);
      ew.delete();
      ew.push_back({3'd2, 16'd1000});
      ew.push_back({3'd3, 16'd0});
      ew.push_back({3'd1, 16'h0005});
      ew.push_back({3'd1, 16'h0008});
      ew.push_back({3'd0, 16'h0000});
      compare_writes("abort_wr");
`endif

      check("bus_protocol", bad_bus, 0);
      check("done_pulse_shape", bad_done, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
